// File: rtl/io_input_port_reader_if.sv
// io_input_port_reader_if: processor read strobe/address, raw input pins and read/pending results.
interface io_input_port_reader_if #(
  parameter int N = 4,
  parameter int M = 16,
  parameter int W = 4
);
  logic           rd_en;
  logic [N-1:0]   addr;
  logic [M*W-1:0] port_in;
  logic [W-1:0]   rd_data;
  logic           rd_valid;
  logic [M-1:0]   pend;
  logic           pend_any;
  logic [N-1:0]   pend_idx;
  modport master(output rd_en, addr, port_in, input rd_data, rd_valid, pend, pend_any, pend_idx);
  modport slave(input rd_en, addr, port_in, output rd_data, rd_valid, pend, pend_any, pend_idx);
endinterface

// File: rtl/io_input_port_reader.sv
// io_input_port_reader: synchronized input-port read mux with per-port change-pending flags and lowest-pending encoder.
// Define IO_IN_SYNC_EN for a two-flop synchronizer per input bit; otherwise a single capture register.
module io_input_port_reader #(
  parameter int N = 4,
  parameter int M = 16,
  parameter int W = 4
) (
  input logic clk,
  input logic rst_n,
  io_input_port_reader_if.slave bus
);
`ifdef IO_IN_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif
  localparam logic [1:0] PRIME_MAX = 2'(SYNC_DEPTH + 1);
  logic [SYNC_DEPTH-1:0][M*W-1:0] sync_q, sync_d;
  logic [M*W-1:0]       port_p_q, port_p_d, port_s;
  logic [1:0]           prime_cnt_q, prime_cnt_d;
  logic [M-1:0]         pend_q, pend_d, change, clr;
  logic [W-1:0]         rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d, primed;
  logic [2**N-1:0][W-1:0] port_tab;
  logic [N-1:0]         pend_idx;
  assign port_s = sync_q[SYNC_DEPTH-1];
  assign primed = prime_cnt_q == PRIME_MAX;
  // Addresses beyond the last port read back as zero.
  genvar k;
  for (k = 0; k < 2**N; k++) begin : g_port
    if (k < M) begin : g_in
      assign port_tab[k] = port_s[k*W +: W];
      assign change[k]   = port_s[k*W +: W] != port_p_q[k*W +: W];
    end else begin : g_pad
      assign port_tab[k] = '0;
    end
  end
  always_comb begin
    sync_d[0] = bus.port_in;
    for (int i = 1; i < SYNC_DEPTH; i++) sync_d[i] = sync_q[i-1];
    port_p_d    = port_s;
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 2'd1;
    clr         = bus.rd_en ? M'(1) << bus.addr : '0;
    // A new edge on the port being read wins over the read's clear.
    pend_d      = (pend_q & ~clr) | (change & {M{primed}});
    rd_valid_d  = bus.rd_en;
    rd_data_d   = bus.rd_en ? port_tab[bus.addr] : rd_data_q;
  end
  always_comb begin
    pend_idx = '0;
    for (int i = M - 1; i >= 0; i--) if (pend_q[i]) pend_idx = N'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      port_p_q    <= '0;
      prime_cnt_q <= '0;
      pend_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      port_p_q    <= port_p_d;
      prime_cnt_q <= prime_cnt_d;
      pend_q      <= pend_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.pend     = pend_q;
  assign bus.pend_any = |pend_q;
  assign bus.pend_idx = pend_idx;
endmodule

// File: tb/tb_io_input_port_reader.sv
// tb_io_input_port_reader: scenario tasks plus a read-data scoreboard for io_input_port_reader.
module tb_io_input_port_reader;
  localparam int N = 4, M = 16, W = 4;
`ifdef IO_IN_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  io_input_port_reader_if #(.N(N), .M(M), .W(W)) bus();
  io_input_port_reader #(.N(N), .M(M), .W(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end
  always @(posedge clk) begin
    #1;
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: rd_valid=1 rd_data=%h with no read outstanding, required rd_valid=0", bus.rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rd_data !== mon_e) begin
          fails++;
          $display("FAIL sb_rd_data: got %h, required %h", bus.rd_data, mon_e);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_port(input int p, input logic [W-1:0] v);
    bus.port_in[p*W +: W] = v;
  endtask
  task automatic drive_read(input logic [N-1:0] a, input logic [W-1:0] e);
    bus.rd_en = 1'b1;
    bus.addr = a;
    exp_q.push_back(e);
  endtask
  task automatic test_reset();
    bus.rd_en = 1'b0;
    bus.addr = '0;
    bus.port_in = '0;
    set_port(1, 4'hA);
    repeat (2) step();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 4'h0 || bus.pend !== '0 || bus.pend_any !== 1'b0 || bus.pend_idx !== '0) begin
      fails++;
      $display("FAIL reset_state: rd_valid=%b rd_data=%h pend=%h any=%b idx=%0d, required all zero",
               bus.rd_valid, bus.rd_data, bus.pend, bus.pend_any, bus.pend_idx);
    end
    rst_n = 1'b1;
    repeat (SD + 3) step();
    checks++;
    if (bus.pend !== '0 || bus.pend_any !== 1'b0 || bus.pend_idx !== '0) begin
      fails++;
      $display("FAIL prime_mask: pend=%h any=%b idx=%0d, required 0 0 0", bus.pend, bus.pend_any, bus.pend_idx);
    end
    drive_read(4'd1, 4'hA);
    step();
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_read_valid: rd_valid=%b, required 1", bus.rd_valid);
    end
    bus.rd_en = 1'b0;
    step();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_read_pulse: rd_valid=%b, required 0", bus.rd_valid);
    end
  endtask
  task automatic test_single_change();
    set_port(3, 4'h5);
    repeat (SD) step();
    checks++;
    if (bus.pend[3] !== 1'b0) begin
      fails++;
      $display("FAIL pend3_early: pend[3]=%b, required 0", bus.pend[3]);
    end
    step();
    checks++;
    if (bus.pend !== 16'h0008 || bus.pend_idx !== 4'd3 || bus.pend_any !== 1'b1) begin
      fails++;
      $display("FAIL pend3_set: pend=%h idx=%0d any=%b, required 0008 3 1", bus.pend, bus.pend_idx, bus.pend_any);
    end
    drive_read(4'd3, 4'h5);
    step();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.pend !== '0) begin
      fails++;
      $display("FAIL pend3_clear: rd_valid=%b pend=%h, required 1 0000", bus.rd_valid, bus.pend);
    end
    step();
  endtask
  task automatic test_two_changes();
    set_port(9, 4'h7);
    set_port(2, 4'hC);
    repeat (SD + 1) step();
    checks++;
    if (bus.pend !== 16'h0204 || bus.pend_idx !== 4'd2) begin
      fails++;
      $display("FAIL two_pend: pend=%h idx=%0d, required 0204 2", bus.pend, bus.pend_idx);
    end
    drive_read(4'd2, 4'hC);
    step();
    checks++;
    if (bus.pend_idx !== 4'd9 || bus.pend_any !== 1'b1) begin
      fails++;
      $display("FAIL two_after2: idx=%0d any=%b, required 9 1", bus.pend_idx, bus.pend_any);
    end
    drive_read(4'd9, 4'h7);
    step();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.pend_any !== 1'b0 || bus.pend_idx !== 4'd0) begin
      fails++;
      $display("FAIL two_after9: any=%b idx=%0d, required 0 0", bus.pend_any, bus.pend_idx);
    end
    step();
  endtask
  task automatic test_same_edge();
    set_port(6, 4'h3);
    repeat (SD) step();
    checks++;
    if (bus.pend[6] !== 1'b0) begin
      fails++;
      $display("FAIL same_edge_pre: pend[6]=%b, required 0", bus.pend[6]);
    end
    drive_read(4'd6, 4'h3);
    step();
    checks++;
    if (bus.pend[6] !== 1'b1) begin
      fails++;
      $display("FAIL same_edge_setwins: pend[6]=%b, required 1", bus.pend[6]);
    end
    drive_read(4'd6, 4'h3);
    step();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.pend[6] !== 1'b0 || bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL same_edge_reread: pend[6]=%b rd_valid=%b, required 0 1", bus.pend[6], bus.rd_valid);
    end
    step();
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) set_port(i, W'(i + 1));
    repeat (SD + 2) step();
    for (int i = 0; i < 4; i++) begin
      drive_read(N'(i), W'(i + 1));
      step();
      checks++;
      if (bus.rd_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_valid[%0d]: rd_valid=%b, required 1", i, bus.rd_valid);
      end
    end
    bus.rd_en = 1'b0;
    step();
    checks++;
    if (bus.rd_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_end: rd_valid=%b outstanding=%0d, required 0 0", bus.rd_valid, exp_q.size());
    end
  endtask
  task automatic test_reset_mid_read();
    int n;
    bus.rd_en = 1'b1;
    bus.addr = 4'd1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 4'h0 || bus.pend !== '0) begin
      fails++;
      $display("FAIL midrd_reset: rd_valid=%b rd_data=%h pend=%h, required 0 0 0000", bus.rd_valid, bus.rd_data, bus.pend);
    end
    repeat (2) step();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrd_held: rd_valid=%b, required 0", bus.rd_valid);
    end
    bus.rd_en = 1'b0;
    rst_n = 1'b1;
    repeat (SD + 3) step();
    checks++;
    if (bus.pend !== '0) begin
      fails++;
      $display("FAIL midrd_reprime: pend=%h, required 0000", bus.pend);
    end
    set_port(0, 4'hF);
    n = 0;
    while (bus.pend[0] !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n != SD + 1) begin
      fails++;
      $display("FAIL latency: pend[0] after %0d cycles, required %0d", n, SD + 1);
    end
  endtask
  initial begin
    test_reset();
    test_single_change();
    test_two_changes();
    test_same_edge();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d reads outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
